// File: rtl/rob_commit_if.sv
// Bus bundle for the reorder/commit buffer. Rename and writeback drive it,
// and the ROB answers with tags, occupancy and the in-order commit stream.
interface rob_commit_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
);

  typedef struct packed {
    logic       valid;
    logic       is_branch;
    logic       rd_valid;
    logic [5:0] rd_idx;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
    logic       ready;
  } p_reg_t;

  rinstr_t          rinstr_i;
  logic [TAG_W-1:0] rob_tag_o;
  logic             rob_full_o;
  logic             wb_valid_i;
  logic [TAG_W-1:0] wb_tag_i;
  br_result_t       br_result_i;
  p_reg_t           p_commit_o;
  logic             retire_o;
  logic [TAG_W:0]   rob_count_o;

  modport master (
    output rinstr_i, wb_valid_i, wb_tag_i, br_result_i,
    input  rob_tag_o, rob_full_o, p_commit_o, retire_o, rob_count_o
  );

  modport slave (
    input  rinstr_i, wb_valid_i, wb_tag_i, br_result_i,
    output rob_tag_o, rob_full_o, p_commit_o, retire_o, rob_count_o
  );

endinterface

// File: rtl/rob_commit.sv
// In-order retirement buffer. Accepts renamed instructions at the tail,
// marks them done on writeback, retires at most one per cycle from the head
// and reports the retired destination register back to rename. A single
// outstanding branch is tracked; a mispredict drops every younger entry.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_ni,
  rob_commit_if.slave  bus
);

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W-1:0] br_tag_q;
  logic [TAG_W:0]   count_q;
  logic [TAG_W:0]   count_d;
  logic             full_q;
  logic             br_pending_q;

  logic [DEPTH-1:0] ent_valid_q;
  logic [DEPTH-1:0] ent_done_q;
  logic [DEPTH-1:0] ent_valid_d;
  logic [DEPTH-1:0] ent_done_d;
  logic [DEPTH-1:0] ent_rd_valid_q;
  logic [5:0]       ent_rd_idx_q [DEPTH];

  logic             retire_p1;
  logic             commit_vld_p1;
  logic [5:0]       commit_idx_p1;
  logic             commit_rdy_p1;

  logic             enq_req;
  logic             enq_ok;
  logic             br_resolve;
  logic             mispredict;
  logic             retire;
  logic [TAG_W-1:0] br_off;
  logic [DEPTH-1:0] flush_mask;

  assign enq_req    = bus.rinstr_i.valid && !full_q;
  assign br_resolve = bus.br_result_i.valid && br_pending_q;
  assign mispredict = br_resolve && !bus.br_result_i.hit;
  // Anything presented alongside a mispredict is on the wrong path.
  assign enq_ok     = enq_req && !mispredict;
  assign retire     = ent_valid_q[head_q] && ent_done_q[head_q];
  // Age of the branch measured from the head; wraps naturally in TAG_W bits.
  assign br_off     = br_tag_q - head_q;

  // Mark every slot whose age from the head exceeds the branch's age.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mispredict && ((TAG_W'(i) - head_q) > br_off)) begin
        flush_mask[i] = 1'b1;
      end
    end
  end

  // Next occupancy: rebuilt from the branch position on a flush.
  always_comb begin
    if (mispredict) begin
      count_d = {1'b0, br_off} + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
    end else begin
      count_d = count_q + (TAG_W+1)'(enq_ok) - (TAG_W+1)'(retire);
    end
  end

  // Next valid/done vectors: writeback, retire, flush, then enqueue.
  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_done_d  = ent_done_q;
    if (bus.wb_valid_i && ent_valid_q[bus.wb_tag_i]) begin
      ent_done_d[bus.wb_tag_i] = 1'b1;
    end
    if (retire) begin
      ent_valid_d[head_q] = 1'b0;
    end
    ent_valid_d = ent_valid_d & ~flush_mask;
    if (enq_ok) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_done_d[tail_q]  = 1'b0;
    end
  end

  // Pointers, occupancy, branch tracking and per-entry status.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      br_pending_q <= 1'b0;
      br_tag_q     <= '0;
      ent_valid_q  <= '0;
      ent_done_q   <= '0;
    end else begin
      count_q     <= count_d;
      full_q      <= (count_d == (TAG_W+1)'(DEPTH));
      ent_valid_q <= ent_valid_d;
      ent_done_q  <= ent_done_d;
      if (retire) begin
        head_q <= head_q + 1'b1;
      end
      if (mispredict) begin
        tail_q <= br_tag_q + 1'b1;
      end else if (enq_ok) begin
        tail_q <= tail_q + 1'b1;
      end
      if (enq_ok && bus.rinstr_i.is_branch) begin
        br_pending_q <= 1'b1;
        br_tag_q     <= tail_q;
      end else if (br_resolve) begin
        br_pending_q <= 1'b0;
      end
    end
  end

  // Entry payload captured at enqueue; only read once the entry is valid.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      ent_rd_valid_q[tail_q] <= bus.rinstr_i.rd_valid;
      ent_rd_idx_q[tail_q]   <= bus.rinstr_i.rd_idx;
    end
  end

  // ---- stage p1: registered commit report of the head just retired ----
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_p1     <= 1'b0;
      commit_vld_p1 <= 1'b0;
      commit_idx_p1 <= '0;
      commit_rdy_p1 <= 1'b0;
    end else begin
      retire_p1     <= retire;
      commit_vld_p1 <= retire && ent_rd_valid_q[head_q];
      commit_idx_p1 <= retire ? ent_rd_idx_q[head_q] : 6'd0;
      commit_rdy_p1 <= retire;
    end
  end

  assign bus.rob_tag_o   = tail_q;
  assign bus.rob_full_o  = full_q;
  assign bus.rob_count_o = count_q;
  assign bus.retire_o    = retire_p1;
  assign bus.p_commit_o  = {commit_vld_p1, commit_idx_p1, commit_rdy_p1};

  // Upstream must stall on rob_full_o; an instruction offered while full is lost.
  a_no_enq_when_full : assert property (
    @(posedge clk) disable iff (!rst_ni) !(bus.rinstr_i.valid && full_q));

  // Only one unresolved branch may be in flight.
  a_single_branch : assert property (
    @(posedge clk) disable iff (!rst_ni)
    !(bus.rinstr_i.valid && bus.rinstr_i.is_branch && br_pending_q && !bus.br_result_i.valid));

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: expected commits are queued at enqueue time and
// popped by a monitor whenever the ROB reports a retirement.
module tb_rob_commit;

  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rob_commit_if #(.DEPTH(DEPTH)) bus();

  rob_commit #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [5:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_retired = 0;
  int   base;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rinstr_i    = '0;
    bus.wb_valid_i  = 1'b0;
    bus.wb_tag_i    = '0;
    bus.br_result_i = '0;
  endtask

  task automatic enq(input logic br, input logic rv, input logic [5:0] idx);
    bus.rinstr_i = '{valid: 1'b1, is_branch: br, rd_valid: rv, rd_idx: idx};
    sb.push_back('{v: rv, idx: idx});
    step();
    bus.rinstr_i = '0;
  endtask

  task automatic wb(input logic [3:0] t);
    bus.wb_valid_i = 1'b1;
    bus.wb_tag_i   = t;
    step();
    bus.wb_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Retirement monitor: every reported commit must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.retire_o) begin
      n_retired++;
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("commit_valid", 32'(bus.p_commit_o.valid), 32'(mon_e.v));
        if (mon_e.v) check_val("commit_idx", 32'(bus.p_commit_o.idx), 32'(mon_e.idx));
        check_val("commit_ready", 32'(bus.p_commit_o.ready), 32'd1);
      end
    end
  end

  initial begin
    idle();
    step();
    step();
    check_val("rst_count", 32'(bus.rob_count_o), 32'd0);
    check_val("rst_full", 32'(bus.rob_full_o), 32'd0);
    check_val("rst_retire", 32'(bus.retire_o), 32'd0);
    check_val("rst_commit", 32'(bus.p_commit_o), 32'd0);
    check_val("rst_tag", 32'(bus.rob_tag_o), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of operation
    for (int i = 0; i < 5; i++) enq(1'b0, 1'b1, 6'(i + 1));
    check_val("t1_count5", 32'(bus.rob_count_o), 32'd5);
    check_val("t1_tag5", 32'(bus.rob_tag_o), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check_val("t1_async_count", 32'(bus.rob_count_o), 32'd0);
    check_val("t1_async_full", 32'(bus.rob_full_o), 32'd0);
    check_val("t1_async_retire", 32'(bus.retire_o), 32'd0);
    check_val("t1_async_commit", 32'(bus.p_commit_o), 32'd0);
    check_val("t1_async_tag", 32'(bus.rob_tag_o), 32'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    step();
    check_val("t1_tag_after_rst", 32'(bus.rob_tag_o), 32'd0);

    // In-order retire with out-of-order writeback
    enq(1'b0, 1'b1, 6'd33);
    check_val("t2_tag1", 32'(bus.rob_tag_o), 32'd1);
    enq(1'b0, 1'b1, 6'd34);
    enq(1'b0, 1'b1, 6'd35);
    wb(4'd2);
    wb(4'd1);
    wb(4'd0);
    check_val("t2_retire_early", 32'(bus.retire_o), 32'd0);
    step();
    check_val("t2_retire0", 32'(bus.retire_o), 32'd1);
    check_val("t2_idx0", 32'(bus.p_commit_o.idx), 32'd33);
    step();
    check_val("t2_idx1", 32'(bus.p_commit_o.idx), 32'd34);
    step();
    check_val("t2_idx2", 32'(bus.p_commit_o.idx), 32'd35);
    step();
    check_val("t2_retire_done", 32'(bus.retire_o), 32'd0);
    check_val("t2_count0", 32'(bus.rob_count_o), 32'd0);

    // Full, stall and wrap-around
    do_reset();
    for (int i = 0; i < DEPTH; i++) enq(1'b0, 1'b1, 6'(10 + i));
    check_val("t3_full", 32'(bus.rob_full_o), 32'd1);
    check_val("t3_count16", 32'(bus.rob_count_o), 32'd16);
    check_val("t3_tag_wrap", 32'(bus.rob_tag_o), 32'd0);
    wb(4'd0);
    check_val("t3_full_hold", 32'(bus.rob_full_o), 32'd1);
    step();
    check_val("t3_retire", 32'(bus.retire_o), 32'd1);
    check_val("t3_not_full", 32'(bus.rob_full_o), 32'd0);
    check_val("t3_count15", 32'(bus.rob_count_o), 32'd15);
    check_val("t3_free_tag", 32'(bus.rob_tag_o), 32'd0);
    enq(1'b0, 1'b1, 6'd50);
    check_val("t3_refull", 32'(bus.rob_full_o), 32'd1);
    check_val("t3_recount", 32'(bus.rob_count_o), 32'd16);

    // Mispredict flush
    do_reset();
    enq(1'b0, 1'b1, 6'd20);
    enq(1'b1, 1'b1, 6'd21);
    enq(1'b0, 1'b1, 6'd22);
    enq(1'b0, 1'b1, 6'd23);
    check_val("t4_count4", 32'(bus.rob_count_o), 32'd4);
    bus.br_result_i = '{valid: 1'b1, hit: 1'b0};
    bus.rinstr_i    = '{valid: 1'b1, is_branch: 1'b0, rd_valid: 1'b1, rd_idx: 6'd40};
    bus.wb_valid_i  = 1'b1;
    bus.wb_tag_i    = 4'd3;
    step();
    idle();
    void'(sb.pop_back());
    void'(sb.pop_back());
    check_val("t4_count2", 32'(bus.rob_count_o), 32'd2);
    check_val("t4_tag2", 32'(bus.rob_tag_o), 32'd2);
    base = n_retired;
    wb(4'd3);
    wb(4'd2);
    check_val("t4_count_after_stale_wb", 32'(bus.rob_count_o), 32'd2);
    wb(4'd0);
    wb(4'd1);
    step();
    step();
    step();
    check_val("t4_retired", 32'(n_retired - base), 32'd2);
    check_val("t4_count0", 32'(bus.rob_count_o), 32'd0);
    check_val("t4_sb_empty", 32'(sb.size()), 32'd0);
    check_val("t4_tag_keep", 32'(bus.rob_tag_o), 32'd2);

    // Branch hit: nothing flushed
    do_reset();
    enq(1'b0, 1'b1, 6'd20);
    enq(1'b1, 1'b1, 6'd21);
    enq(1'b0, 1'b1, 6'd22);
    enq(1'b0, 1'b1, 6'd23);
    bus.br_result_i = '{valid: 1'b1, hit: 1'b1};
    step();
    idle();
    check_val("t5_count4", 32'(bus.rob_count_o), 32'd4);
    check_val("t5_tag4", 32'(bus.rob_tag_o), 32'd4);
    base = n_retired;
    wb(4'd3);
    wb(4'd2);
    wb(4'd1);
    wb(4'd0);
    for (int i = 0; i < 5; i++) step();
    check_val("t5_retired", 32'(n_retired - base), 32'd4);
    check_val("t5_count0", 32'(bus.rob_count_o), 32'd0);
    check_val("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Retire without a destination, overlapped with an enqueue
    do_reset();
    enq(1'b0, 1'b0, 6'd7);
    check_val("t6_count1", 32'(bus.rob_count_o), 32'd1);
    wb(4'd0);
    enq(1'b0, 1'b1, 6'd8);
    check_val("t6_retire", 32'(bus.retire_o), 32'd1);
    check_val("t6_no_rd", 32'(bus.p_commit_o.valid), 32'd0);
    check_val("t6_count_same", 32'(bus.rob_count_o), 32'd1);
    wb(4'd1);
    step();
    step();
    check_val("t6_count0", 32'(bus.rob_count_o), 32'd0);
    check_val("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
